// File: rtl/serial_full_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master issues operands and start; the slave returns sum, carry and status.
interface serial_full_adder_if #(
    parameter int unsigned N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         C0;
    logic [N-1:0] S;
    logic         C;
    logic         busy;
    logic         done;

    modport master (
        output start, A, B, C0,
        input  S, C, busy, done
    );

    modport slave (
        input  start, A, B, C0,
        output S, C, busy, done
    );
endinterface

// File: rtl/serial_full_adder.sv
// Bit-serial N-bit adder: latches A, B and C0 on an accepted start, then adds them LSB-first
// through one full-adder cell and a carry flop. busy frames the N add cycles; done pulses for
// one cycle when S/C hold the result. S/C stay put until the next operation completes.
module serial_full_adder #(
    parameter int unsigned N = 4
) (
    input logic                clk,
    input logic                rst,
    serial_full_adder_if.slave bus
);

    // Counter spans 0..N so it never wraps inside an operation.
    localparam int unsigned CntW = $clog2(N + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            c_q;
    logic [N-1:0]    sum_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    s_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;

    logic            fa_sum;
    logic            fa_carry;
    logic [N-1:0]    sum_shift;
    logic            last_bit;

    // Full-adder cell on the operand LSBs and the carry flop, plus the next sum-register value.
    always_comb begin
        fa_sum         = a_q[0] ^ b_q[0] ^ c_q;
        fa_carry       = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        sum_shift      = sum_q >> 1;
        sum_shift[N-1] = fa_sum;
        last_bit       = (cnt_q == CntW'(N - 1));
    end

    // Control FSM with datapath; every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        c_q     <= bus.C0;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAdd;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StAdd: begin
                    sum_q <= sum_shift;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= fa_carry;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        // Publish the result only here so S/C stay stable between operations.
                        s_q     <= sum_shift;
                        cout_q  <= fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.S    = s_q;
    assign bus.C    = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Scoreboard bench for serial_full_adder (N=4): expected {C,S} = A + B + C0 is queued at issue
// time; a negedge monitor pops and compares on every done pulse and checks S/C stay held.
module tb_serial_full_adder;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_full_adder_if #(.N(N)) bus ();

    serial_full_adder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         issued = 0;
    int         dones_seen = 0;
    logic [4:0] exp_q[$];
    logic [4:0] hold_val = '0;
    bit         hold_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on done, otherwise verify the last result is held while idle.
    always @(negedge clk) begin
        if (hold_en) begin
            if (bus.done) begin
                dones_seen++;
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'(bus.done), 32'(0));
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    check("sum_result", 32'({bus.C, bus.S}), 32'(e));
                    hold_val = e;
                end
            end else if (!bus.busy) begin
                check("result_hold", 32'({bus.C, bus.S}), 32'(hold_val));
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c0);
        bus.A     = a;
        bus.B     = b;
        bus.C0    = c0;
        bus.start = 1'b1;
        exp_q.push_back(5'(a) + 5'(b) + 5'(c0));
        issued++;
    endtask

    // One operation with cycle-exact busy/done checks. noise scrambles inputs and start during
    // ADD; armed means the start was already presented; chain presents the next op on DONE.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic c0,
                          input bit noise, input bit armed, input bit chain,
                          input logic [3:0] na, input logic [3:0] nb, input logic nc);
        if (!armed) begin
            @(posedge clk);
            #1;
            drive(a, b, c0);
        end
        @(posedge clk);
        for (int k = 0; k < int'(N); k++) begin
            #1;
            if (noise) begin
                bus.A     = 4'($urandom);
                bus.B     = 4'($urandom);
                bus.C0    = 1'($urandom);
                bus.start = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            check("busy_in_add", 32'({bus.busy, bus.done}), 32'(2'b10));
            @(posedge clk);
        end
        #1;
        if (chain) drive(na, nb, nc);
        else bus.start = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'({bus.busy, bus.done}), 32'(2'b01));
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #1;
        drive(4'($urandom), 4'($urandom), 1'($urandom));
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issued -= exp_q.size();
        exp_q.delete();
        hold_val = '0;
        @(negedge clk);
        check("mid_reset_state", 32'({bus.C, bus.S, bus.busy, bus.done}), 32'(0));
        repeat (N + 3) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(bus.done), 32'(0));
        end
    endtask

    initial begin
        logic [3:0] a, b, na, nb;
        logic       c0, nc;
        bit         armed, chain;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.C0    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        hold_en = 1'b1;
        @(negedge clk);
        check("reset_state", 32'({bus.C, bus.S, bus.busy, bus.done}), 32'(0));

        // Directed cases.
        run_op(4'b0111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        run_op(4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        run_op(4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        run_op(4'h1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        reset_mid();
        // Back-to-back: second done must land exactly N+1 cycles after the first.
        run_op(4'h9, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'hC, 1'b1);
        run_op(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

        // Exhaustive sweep of {B,A,C0}.
        for (int v = 0; v < 512; v++) begin
            run_op(v[4:1], v[8:5], v[0], 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                   4'h0, 4'h0, 1'b0);
        end

        // Random run with randomly chained operations.
        armed = 1'b0;
        a  = 4'($urandom);
        b  = 4'($urandom);
        c0 = 1'($urandom);
        for (int i = 0; i < 60; i++) begin
            na    = 4'($urandom);
            nb    = 4'($urandom);
            nc    = 1'($urandom);
            chain = (i < 59) && 1'($urandom);
            run_op(a, b, c0, 1'($urandom_range(0, 1)), armed, chain, na, nb, nc);
            armed = chain;
            a  = 4'($urandom);
            b  = 4'($urandom);
            c0 = 1'($urandom);
        end

        repeat (3) @(negedge clk);
        check("done_count", 32'(dones_seen), 32'(issued));
        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
